// File: rtl/sdram_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_sched_pkg
//  Purpose  : Shared types and widths for the SDRAM frame scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package sdram_sched_pkg;

   localparam int SDRAM_AW = 25;   // SDRAM word address width
   localparam int SDRAM_DW = 16;   // SDRAM data width

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_LOAD = 2'd1,
      R_POP  = 2'd2,
      R_DONE = 2'd3
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_GAP    = 2'd1,
      W_LOAD   = 2'd2,
      W_STREAM = 2'd3
   } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_wr_stream.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_wr_stream
//  Purpose  : Game-writer side of the scheduler. Loads the SDRAM write FIFO
//             address, then streams contiguous words; a non-contiguous address
//             waits LD_GAP idle cycles so the FIFO drains before re-loading.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_wr_stream
   import sdram_sched_pkg::*;
#(
   parameter logic [SDRAM_AW-1:0] FB_BASE = 25'h000000,
   parameter int                  LD_GAP  = 64
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                i_gw_valid,
   input  logic [SDRAM_AW-1:0] i_gw_addr,
   input  logic [SDRAM_DW-1:0] i_gw_data,
   input  logic                i_wr_full,
   input  logic                i_block,
   output logic                o_gw_ready,
   output logic                o_write_ld,
   output logic                o_write_req,
   output logic [SDRAM_AW-1:0] o_writeaddr,
   output logic [SDRAM_DW-1:0] o_writedata
);

   localparam int            c_GW       = (LD_GAP < 1) ? 1 : $clog2(LD_GAP + 1);
   localparam logic [c_GW-1:0] c_GAP_INIT = c_GW'(LD_GAP);

   wr_state_t           r_state, w_state_nxt;
   logic [c_GW-1:0]     r_gap;
   logic [SDRAM_AW-1:0] r_wr_next;
   logic [SDRAM_AW-1:0] r_writeaddr;
   logic [SDRAM_DW-1:0] r_writedata;
   logic                r_write_req;
   logic                w_gw_ready;
   logic                w_write_ld;
   logic                w_mismatch;

   // Next-state and handshake decode
   always_comb begin
      w_state_nxt = r_state;
      w_gw_ready  = 1'b0;
      w_write_ld  = 1'b0;
      w_mismatch  = 1'b0;
      case (r_state)
         W_IDLE:   if (i_gw_valid) w_state_nxt = W_LOAD;
         W_GAP:    if (r_gap == '0) w_state_nxt = W_LOAD;
         W_LOAD: begin
            w_write_ld  = 1'b1;
            w_state_nxt = W_STREAM;
         end
         W_STREAM: begin
            w_mismatch = i_gw_valid && (i_gw_addr != r_wr_next);
            w_gw_ready = i_gw_valid && (i_gw_addr == r_wr_next) && !i_wr_full && !i_block;
            if (w_mismatch) w_state_nxt = W_GAP;
         end
         default:  w_state_nxt = W_IDLE;
      endcase
   end

   // State, gap counter, address tracking and FIFO push register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= W_IDLE;
         r_gap       <= '0;
         r_wr_next   <= FB_BASE;
         r_writeaddr <= FB_BASE;
         r_writedata <= '0;
         r_write_req <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_write_req <= w_gw_ready;
         if (w_gw_ready) begin
            r_writedata <= i_gw_data;
            r_wr_next   <= r_wr_next + 1'b1;
         end
         // Address is captured on entry to W_LOAD so write_ld and writeaddr coincide
         if (w_state_nxt == W_LOAD && r_state != W_LOAD)
            r_writeaddr <= i_gw_addr;
         if (r_state == W_LOAD)
            r_wr_next <= r_writeaddr;
         if (w_mismatch)
            r_gap <= c_GAP_INIT;
         else if (r_state == W_GAP && r_gap != '0)
            r_gap <= r_gap - 1'b1;
      end
   end

   assign o_gw_ready  = w_gw_ready;
   assign o_write_ld  = w_write_ld;
   assign o_write_req = r_write_req;
   assign o_writeaddr = r_writeaddr;
   assign o_writedata = r_writedata;

endmodule
`default_nettype wire

// File: rtl/sdram_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_frame_scheduler
//  Purpose  : Drives the Sdram_Control FIFO ports: per-line prefetch into the
//             VGA line buffer plus a streaming game-writer port.
//  Options  : SDRAM_SCHED_STATS_EN adds overrun / write-stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_frame_scheduler
   import sdram_sched_pkg::*;
#(
   parameter logic [SDRAM_AW-1:0] FB_BASE     = 25'h000000,
   parameter int                  LINE_WORDS  = 320,
   parameter int                  LB_AW       = 9,
   parameter int                  LD_GAP      = 64,
   parameter bit                  BLOCK_WR_PF = 1'b1
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                i_line_start,
   input  logic [9:0]          i_line_num,
   input  logic                i_gw_valid,
   output logic                o_gw_ready,
   input  logic [SDRAM_AW-1:0] i_gw_addr,
   input  logic [SDRAM_DW-1:0] i_gw_data,
   output logic                o_lb_we,
   output logic [LB_AW-1:0]    o_lb_addr,
   output logic [SDRAM_DW-1:0] o_lb_wdata,
   output logic                o_line_done,
   output logic                o_overrun,
`ifdef SDRAM_SCHED_STATS_EN
   output logic [15:0]         o_stat_overruns,
   output logic [15:0]         o_stat_wr_stalls,
`endif
   output logic                o_write_ld,
   output logic                o_write_req,
   output logic [SDRAM_AW-1:0] o_writeaddr,
   output logic [SDRAM_DW-1:0] o_writedata,
   input  logic                i_wr_full,
   output logic                o_read_ld,
   output logic                o_read_req,
   output logic [SDRAM_AW-1:0] o_readaddr,
   input  logic [SDRAM_DW-1:0] i_readdata,
   input  logic                i_rd_empty
);

   localparam logic [LB_AW:0] c_LINE_WORDS = (LB_AW + 1)'(LINE_WORDS);

   rd_state_t           r_rd_state, w_rd_state_nxt;
   logic [LB_AW:0]      r_rcnt;
   logic [SDRAM_AW-1:0] r_readaddr;
   logic                r_lb_we;
   logic [LB_AW-1:0]    r_lb_addr;
   logic                r_overrun;
   logic                w_read_req;
   logic                w_rd_busy;
   logic                w_gw_ready;
   logic                w_overrun_evt;

   assign w_rd_busy     = (r_rd_state == R_LOAD) || (r_rd_state == R_POP);
   assign w_overrun_evt = i_line_start && w_rd_busy;

   // Read FSM next state; a new line_start always wins and restarts the fetch
   always_comb begin
      w_rd_state_nxt = r_rd_state;
      w_read_req     = 1'b0;
      case (r_rd_state)
         R_IDLE: ;
         R_LOAD: w_rd_state_nxt = R_POP;
         R_POP: begin
            w_read_req = !i_rd_empty && (r_rcnt < c_LINE_WORDS);
            // rcnt reaches the line length in the cycle of the final lb_we
            if (r_rcnt == c_LINE_WORDS) w_rd_state_nxt = R_DONE;
         end
         R_DONE: w_rd_state_nxt = R_IDLE;
         default: w_rd_state_nxt = R_IDLE;
      endcase
      if (i_line_start) w_rd_state_nxt = R_LOAD;
   end

   // Read state, word counter, line address and line-buffer write pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_state <= R_IDLE;
         r_rcnt     <= '0;
         r_readaddr <= FB_BASE;
         r_lb_we    <= 1'b0;
         r_lb_addr  <= '0;
         r_overrun  <= 1'b0;
      end else begin
         r_rd_state <= w_rd_state_nxt;
         // A read issued in the same cycle as line_start still lands in the buffer
         r_lb_we    <= w_read_req;
         if (w_read_req) r_lb_addr <= r_rcnt[LB_AW-1:0];
         if (i_line_start) begin
            r_rcnt     <= '0;
            r_readaddr <= FB_BASE + SDRAM_AW'(i_line_num) * SDRAM_AW'(LINE_WORDS);
         end else if (w_read_req) begin
            r_rcnt <= r_rcnt + 1'b1;
         end
         if (w_overrun_evt) r_overrun <= 1'b1;
      end
   end

   sdram_wr_stream #(
      .FB_BASE (FB_BASE),
      .LD_GAP  (LD_GAP)
   ) u_wr_stream (
      .clk         (clk),
      .reset       (reset),
      .i_gw_valid  (i_gw_valid),
      .i_gw_addr   (i_gw_addr),
      .i_gw_data   (i_gw_data),
      .i_wr_full   (i_wr_full),
      .i_block     (BLOCK_WR_PF && w_rd_busy),
      .o_gw_ready  (w_gw_ready),
      .o_write_ld  (o_write_ld),
      .o_write_req (o_write_req),
      .o_writeaddr (o_writeaddr),
      .o_writedata (o_writedata)
   );

`ifdef SDRAM_SCHED_STATS_EN
   logic [15:0] r_stat_overruns;
   logic [15:0] r_stat_wr_stalls;

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_overruns  <= '0;
         r_stat_wr_stalls <= '0;
      end else begin
         if (w_overrun_evt && r_stat_overruns != 16'hFFFF)
            r_stat_overruns <= r_stat_overruns + 1'b1;
         if (i_gw_valid && !w_gw_ready && r_stat_wr_stalls != 16'hFFFF)
            r_stat_wr_stalls <= r_stat_wr_stalls + 1'b1;
      end
   end

   assign o_stat_overruns  = r_stat_overruns;
   assign o_stat_wr_stalls = r_stat_wr_stalls;
`endif

   assign o_gw_ready  = w_gw_ready;
   assign o_read_ld   = (r_rd_state == R_LOAD);
   assign o_read_req  = w_read_req;
   assign o_readaddr  = r_readaddr;
   assign o_line_done = (r_rd_state == R_DONE);
   assign o_overrun   = r_overrun;
   assign o_lb_we     = r_lb_we;
   assign o_lb_addr   = r_lb_addr;
   assign o_lb_wdata  = r_lb_we ? i_readdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_sdram_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_frame_scheduler
//  Purpose  : Scoreboard bench for sdram_frame_scheduler (directed vectors).
//  Options  : SDRAM_SCHED_STATS_EN also checks the statistics counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_frame_scheduler;
   import sdram_sched_pkg::*;

   localparam int LW     = 320;
   localparam int LD_GAP = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        line_start = 1'b0;
   logic [9:0]  line_num = '0;
   logic        gw_valid = 1'b0;
   logic        gw_ready;
   logic [24:0] gw_addr = '0;
   logic [15:0] gw_data = '0;
   logic        lb_we;
   logic [8:0]  lb_addr;
   logic [15:0] lb_wdata;
   logic        line_done, overrun;
   logic        write_ld, write_req, read_ld, read_req;
   logic [24:0] writeaddr, readaddr;
   logic [15:0] writedata;
   logic        wr_full;
   logic [15:0] readdata;
   logic        rd_empty;
`ifdef SDRAM_SCHED_STATS_EN
   logic [15:0] stat_overruns, stat_wr_stalls;
`endif

   // stimulus levels (rd_empty / wr_full / readdata are driven by one process)
   logic        empty_lvl = 1'b1;
   logic        full_lvl  = 1'b0;
   logic        tog_en    = 1'b0;
   int          tog_k     = 0;

   always #5 clk = ~clk;

   sdram_frame_scheduler dut (
      .clk(clk), .reset(reset),
      .i_line_start(line_start), .i_line_num(line_num),
      .i_gw_valid(gw_valid), .o_gw_ready(gw_ready),
      .i_gw_addr(gw_addr), .i_gw_data(gw_data),
      .o_lb_we(lb_we), .o_lb_addr(lb_addr), .o_lb_wdata(lb_wdata),
      .o_line_done(line_done), .o_overrun(overrun),
`ifdef SDRAM_SCHED_STATS_EN
      .o_stat_overruns(stat_overruns), .o_stat_wr_stalls(stat_wr_stalls),
`endif
      .o_write_ld(write_ld), .o_write_req(write_req),
      .o_writeaddr(writeaddr), .o_writedata(writedata),
      .i_wr_full(wr_full),
      .o_read_ld(read_ld), .o_read_req(read_req),
      .o_readaddr(readaddr), .i_readdata(readdata),
      .i_rd_empty(rd_empty)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   // SDRAM content model: each word address holds a scrambled value
   function automatic logic [15:0] mem_data(input logic [24:0] a);
      return a[15:0] ^ {a[7:0], a[24:17]} ^ 16'h3C5A;
   endfunction

   // Scoreboard queues
   logic [24:0] q_rdld[$];   // expected readaddr per read_ld
   logic [24:0] q_lb[$];     // expected {lb_addr, lb_wdata}
   logic [24:0] q_wrld[$];   // expected writeaddr per write_ld
   logic [15:0] q_wrd[$];    // expected writedata per write_req

   // Model state
   logic [24:0] m_rd_base = '0;
   int          m_rd_idx  = 0;
   logic        m_busy    = 1'b0;
   logic        pend      = 1'b0;
   logic [15:0] pend_data = '0;
   logic        prev_full = 1'b0;
   int          prev_lb   = -1;
   int          n_read_req = 0, n_line_done = 0, n_wr_req = 0, n_wr_ld = 0, n_stall = 0;
   logic        m_wr_started = 1'b0;
   logic [24:0] m_wr_next = '0;

   // SDRAM-side drive: readdata valid the cycle after each read_req
   always @(posedge clk) begin
      #1;
      readdata = pend ? pend_data : 16'hDEAD;
      wr_full  = full_lvl;
      if (tog_en) begin
         tog_k++;
         rd_empty = (tog_k % 3 == 0);
      end else begin
         rd_empty = empty_lvl;
      end
   end

   // Monitor: pops and compares whenever the DUT presents an output
   always @(negedge clk) begin
      logic [24:0] e;
      logic [15:0] d;
      if (!reset) begin
         if (read_ld) begin
            if (q_rdld.size() == 0) fail_now("read_ld unexpected");
            else begin
               e = q_rdld.pop_front();
               check("readaddr", 32'(readaddr), 32'(e));
               m_rd_base = e;
            end
            m_rd_idx = 0;
            m_busy   = 1'b1;
         end
         if (lb_we) begin
            if (q_lb.size() == 0) fail_now("lb_we unexpected");
            else begin
               e = q_lb.pop_front();
               check("lb addr/data", 32'({lb_addr, lb_wdata}), 32'(e));
            end
         end
         if (line_done) begin
            n_line_done++;
            check("line_done after last word", 32'(prev_lb), 32'(LW - 1));
            m_busy = 1'b0;
         end
         prev_lb = lb_we ? int'(lb_addr) : -1;
         if (read_req) begin
            check("read_req while empty", 32'(rd_empty), 32'd0);
            n_read_req++;
            d = mem_data(m_rd_base + 25'(m_rd_idx));
            q_lb.push_back({9'(m_rd_idx), d});
            pend      = 1'b1;
            pend_data = d;
            m_rd_idx++;
         end else begin
            pend = 1'b0;
         end
         if (m_busy) check("gw_ready during prefetch", 32'(gw_ready), 32'd0);
         if (write_ld) begin
            n_wr_ld++;
            if (q_wrld.size() == 0) fail_now("write_ld unexpected");
            else check("writeaddr", 32'(writeaddr), 32'(q_wrld.pop_front()));
         end
         if (write_req) begin
            n_wr_req++;
            check("write_req after wr_full", 32'(prev_full), 32'd0);
            if (q_wrd.size() == 0) fail_now("write_req unexpected");
            else check("writedata", 32'(writedata), 32'(q_wrd.pop_front()));
         end
         if (gw_valid && !gw_ready) n_stall++;
         prev_full = wr_full;
      end else begin
         pend = 1'b0;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_line(input int n);
      line_start = 1'b1;
      line_num   = 10'(n);
      q_rdld.push_back(25'(n * LW));
      cycles(1);
      line_start = 1'b0;
   endtask

   task automatic wait_line_done(input int start_cnt);
      int k;
      for (k = 0; k < 3000; k++) begin
         if (n_line_done > start_cnt) break;
         cycles(1);
      end
      if (k == 3000) fail_now("line_done timeout");
   endtask

   task automatic gw_write(input logic [24:0] a, input logic [15:0] d, output int lowc);
      logic done;
      done = 1'b0;
      lowc = 0;
      if (!m_wr_started || a != m_wr_next) q_wrld.push_back(a);
      m_wr_started = 1'b1;
      m_wr_next    = a + 25'd1;
      q_wrd.push_back(d);
      gw_valid = 1'b1;
      gw_addr  = a;
      gw_data  = d;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (gw_ready) begin
            done = 1'b1;
            break;
         end
         lowc++;
      end
      if (!done) fail_now("gw handshake timeout");
      cycles(1);
      gw_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lc, base_rr, base_ld, base_wr, base_wl;

      // ---- reset state ----
      cycles(3);
      @(negedge clk);
      check("reset read_ld", 32'(read_ld), 32'd0);
      check("reset write_req", 32'(write_req), 32'd0);
      check("reset lb_we", 32'(lb_we), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      check("reset readaddr", 32'(readaddr), 32'd0);
      check("reset writeaddr", 32'(writeaddr), 32'd0);
      check("reset gw_ready", 32'(gw_ready), 32'd0);
      cycles(1);
      reset = 1'b0;
      cycles(2);

      // ---- 1: full line 2 with data always available ----
      empty_lvl = 1'b0;
      cycles(1);
      base_rr = n_read_req; base_ld = n_line_done;
      pulse_line(2);
      wait_line_done(base_ld);
      cycles(3);
      check("t1 read_req count", 32'(n_read_req - base_rr), 32'(LW));
      check("t1 line_done count", 32'(n_line_done - base_ld), 32'd1);
      check("t1 overrun", 32'(overrun), 32'd0);

      // ---- 2: rd_empty every 3rd cycle ----
      tog_en = 1'b1;
      base_rr = n_read_req; base_ld = n_line_done;
      pulse_line(7);
      wait_line_done(base_ld);
      tog_en = 1'b0;
      cycles(3);
      check("t2 read_req count", 32'(n_read_req - base_rr), 32'(LW));
      check("t2 lb queue drained", 32'(q_lb.size()), 32'd0);

      // ---- 3: restart at rcnt=100 with line 5 ----
      base_ld = n_line_done;
      pulse_line(1);
      for (int k = 0; k < 1000 && m_rd_idx < 100; k++) cycles(1);
      check("t3 reached word 100", 32'(m_rd_idx >= 100), 32'd1);
      pulse_line(5);
      wait_line_done(base_ld);
      cycles(5);
      check("t3 overrun", 32'(overrun), 32'd1);
      check("t3 single line_done", 32'(n_line_done - base_ld), 32'd1);
      cycles(10);
      check("t3 overrun sticky", 32'(overrun), 32'd1);

      // ---- 4: contiguous writes ----
      base_wr = n_wr_req; base_wl = n_wr_ld;
      gw_write(25'h10, 16'hA110, lc);
      gw_write(25'h11, 16'hB221, lc);
      gw_write(25'h12, 16'hC332, lc);
      cycles(4);
      check("t4 write_req count", 32'(n_wr_req - base_wr), 32'd3);
      check("t4 write_ld count", 32'(n_wr_ld - base_wl), 32'd1);

      // ---- 5: non-contiguous write forces gap + reload ----
      gw_write(25'h10, 16'h1234, lc);
      gw_write(25'h80, 16'h5678, lc);
      check("t5 gap ready-low lower bound", 32'(lc >= LD_GAP + 1), 32'd1);
      check("t5 gap ready-low upper bound", 32'(lc <= LD_GAP + 4), 32'd1);
      cycles(4);

      // ---- 6: wr_full mid-stream and prefetch blocking ----
      empty_lvl = 1'b0;
      base_wr = n_wr_req; base_ld = n_line_done;
      fork
         begin
            for (int i = 0; i < 12; i++)
               gw_write(25'h200 + 25'(i), 16'hE000 + 16'(i * 37), lc);
         end
         begin
            int k;
            for (k = 0; k < 2000 && (n_wr_req - base_wr) < 2; k++) cycles(1);
            if (k == 2000) fail_now("t6 stream start timeout");
            full_lvl = 1'b1;
            cycles(5);
            full_lvl = 1'b0;
            cycles(2);
            pulse_line(3);
         end
      join
      wait_line_done(base_ld);
      cycles(5);
      check("t6 write_req count", 32'(n_wr_req - base_wr), 32'd12);
      check("t6 write queue drained", 32'(q_wrd.size()), 32'd0);
      check("t6 write_ld queue drained", 32'(q_wrld.size()), 32'd0);
      check("t6 read_ld queue drained", 32'(q_rdld.size()), 32'd0);
      check("t6 lb queue drained", 32'(q_lb.size()), 32'd0);
`ifdef SDRAM_SCHED_STATS_EN
      check("stat_wr_stalls", 32'(stat_wr_stalls), 32'(n_stall));
      check("stat_overruns", 32'(stat_overruns), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
